// File: rtl/ps2_scancode_decoder.sv
// PS/2 set-2 scancode decoder: drains the receiver FIFO and assembles make/break/E0 key events.
// Optional feature macro: SHIFT_CASE_EN (shift-key tracking and uppercase letters).
`timescale 1ns/1ps
module ps2_scancode_decoder #(
    parameter int CNT_W      = 8,
    parameter bit IGNORE_BAT = 1'b1
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic [7:0]       ps2_data,
    input  logic             ps2_ready,
    input  logic             ps2_overflow,
    output logic             ps2_nextdata_n,
    output logic             event_valid,
    output logic [7:0]       event_code,
    output logic             event_ext,
    output logic             event_break,
    output logic             event_repeat,
    output logic [7:0]       ascii,
    output logic             key_held,
    output logic [8:0]       held_code,
    output logic [CNT_W-1:0] press_count,
    output logic             err_overflow,
    output logic             err_seq
);

    typedef enum logic {HS_IDLE, HS_POP} hs_state_t;
    typedef enum logic [1:0] {SQ_BASE, SQ_EXT, SQ_BRK, SQ_EXT_BRK} sq_state_t;

    hs_state_t  hs_state, hs_next;
    sq_state_t  sq_state, sq_next, sq_eff;
    logic [7:0] byte_q;
    logic       byte_vld;
    logic       ev_fire, ev_ext, ev_brk, seq_err;
    logic [8:0] ev_key;
    logic       ev_match, ev_shift, shift_dn;

    function automatic logic [7:0] to_ascii(input logic [7:0] code, input logic upper);
        logic [7:0] a;
        case (code)
            8'h1C: a = 8'h61; 8'h32: a = 8'h62; 8'h21: a = 8'h63; 8'h23: a = 8'h64;
            8'h24: a = 8'h65; 8'h2B: a = 8'h66; 8'h34: a = 8'h67; 8'h33: a = 8'h68;
            8'h43: a = 8'h69; 8'h3B: a = 8'h6A; 8'h42: a = 8'h6B; 8'h4B: a = 8'h6C;
            8'h3A: a = 8'h6D; 8'h31: a = 8'h6E; 8'h44: a = 8'h6F; 8'h4D: a = 8'h70;
            8'h15: a = 8'h71; 8'h2D: a = 8'h72; 8'h1B: a = 8'h73; 8'h2C: a = 8'h74;
            8'h3C: a = 8'h75; 8'h2A: a = 8'h76; 8'h1D: a = 8'h77; 8'h22: a = 8'h78;
            8'h35: a = 8'h79; 8'h1A: a = 8'h7A;
            8'h45: a = 8'h30; 8'h16: a = 8'h31; 8'h1E: a = 8'h32; 8'h26: a = 8'h33;
            8'h25: a = 8'h34; 8'h2E: a = 8'h35; 8'h36: a = 8'h36; 8'h3D: a = 8'h37;
            8'h3E: a = 8'h38; 8'h46: a = 8'h39;
            8'h29: a = 8'h20; 8'h5A: a = 8'h0D; 8'h66: a = 8'h08;
            default: a = 8'h00;
        endcase
        if (upper && a >= 8'h61 && a <= 8'h7A)
            a = a - 8'h20;
        return a;
    endfunction

    // Handshake: at most one capture every two cycles, ready ignored while popping
    always_comb begin
        hs_next = HS_IDLE;
        if (hs_state == HS_IDLE && ps2_ready)
            hs_next = HS_POP;
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            hs_state       <= HS_IDLE;
            byte_q         <= '0;
            ps2_nextdata_n <= 1'b1;
        end else begin
            hs_state       <= hs_next;
            ps2_nextdata_n <= (hs_next != HS_POP);
            if (hs_next == HS_POP)
                byte_q <= ps2_data;
        end
    end

    assign byte_vld = (hs_state == HS_POP);

    always_comb begin
        sq_next = sq_state;
        sq_eff  = sq_state;
        ev_fire = 1'b0;
        ev_ext  = 1'b0;
        ev_brk  = 1'b0;
        seq_err = 1'b0;
        if (byte_vld) begin
            // Illegal prefix order: flag it and reinterpret the byte from BASE
            if ((byte_q == 8'hE0 && sq_state != SQ_BASE) ||
                (byte_q == 8'hF0 && (sq_state == SQ_BRK || sq_state == SQ_EXT_BRK))) begin
                seq_err = 1'b1;
                sq_eff  = SQ_BASE;
            end
            case (sq_eff)
                SQ_BASE: begin
                    if (byte_q == 8'hE0)
                        sq_next = SQ_EXT;
                    else if (byte_q == 8'hF0)
                        sq_next = SQ_BRK;
                    else if (!(IGNORE_BAT && byte_q == 8'hAA))
                        ev_fire = 1'b1;
                end
                SQ_EXT: begin
                    if (byte_q == 8'hF0) begin
                        sq_next = SQ_EXT_BRK;
                    end else begin
                        ev_fire = 1'b1;
                        ev_ext  = 1'b1;
                        sq_next = SQ_BASE;
                    end
                end
                SQ_BRK: begin
                    ev_fire = 1'b1;
                    ev_brk  = 1'b1;
                    sq_next = SQ_BASE;
                end
                default: begin
                    ev_fire = 1'b1;
                    ev_ext  = 1'b1;
                    ev_brk  = 1'b1;
                    sq_next = SQ_BASE;
                end
            endcase
        end
        // Overflow drops any partial prefix and any event due on the same edge
        if (ps2_overflow) begin
            sq_next = SQ_BASE;
            ev_fire = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn)
            sq_state <= SQ_BASE;
        else
            sq_state <= sq_next;
    end

    assign ev_key   = {ev_ext, byte_q};
    assign ev_match = key_held && (held_code == ev_key);

`ifdef SHIFT_CASE_EN
    logic shift_l, shift_r;
    assign shift_dn = shift_l | shift_r;
    assign ev_shift = !ev_ext && (byte_q == 8'h12 || byte_q == 8'h59);

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            shift_l <= 1'b0;
            shift_r <= 1'b0;
        end else if (ev_fire && ev_shift) begin
            if (byte_q == 8'h12)
                shift_l <= !ev_brk;
            else
                shift_r <= !ev_brk;
        end
    end
`else
    assign shift_dn = 1'b0;
    assign ev_shift = 1'b0;
`endif

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            event_valid  <= 1'b0;
            event_code   <= '0;
            event_ext    <= 1'b0;
            event_break  <= 1'b0;
            event_repeat <= 1'b0;
            ascii        <= '0;
            key_held     <= 1'b0;
            held_code    <= '0;
            press_count  <= '0;
            err_overflow <= 1'b0;
            err_seq      <= 1'b0;
        end else begin
            event_valid  <= ev_fire;
            err_overflow <= err_overflow | ps2_overflow;
            err_seq      <= err_seq | seq_err;
            if (ev_fire) begin
                event_code   <= byte_q;
                event_ext    <= ev_ext;
                event_break  <= ev_brk;
                event_repeat <= !ev_brk && ev_match && !ev_shift;
                ascii        <= ev_ext ? 8'h00 : to_ascii(byte_q, shift_dn);
                if (!ev_brk) begin
                    if (!ev_match && !ev_shift) begin
                        press_count <= press_count + CNT_W'(1);
                        held_code   <= ev_key;
                        key_held    <= 1'b1;
                    end
                end else if (ev_match) begin
                    key_held <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Bench for ps2_scancode_decoder: FIFO-style feeder, prefix-flag reference model, directed literal checks.
`timescale 1ns/1ps
module tb_ps2_scancode_decoder;

    logic       clk = 1'b0;
    logic       clrn = 1'b1;
    logic [7:0] ps2_data = 8'h00;
    logic       ps2_ready = 1'b0;
    logic       ps2_overflow = 1'b0;
    logic       ps2_nextdata_n, event_valid, event_ext, event_break, event_repeat;
    logic [7:0] event_code, ascii, press_count;
    logic       key_held, err_overflow, err_seq;
    logic [8:0] held_code;

    always #5 clk = ~clk;

    ps2_scancode_decoder #(.CNT_W(8), .IGNORE_BAT(1'b1)) dut (
        .clk(clk), .clrn(clrn), .ps2_data(ps2_data), .ps2_ready(ps2_ready),
        .ps2_overflow(ps2_overflow), .ps2_nextdata_n(ps2_nextdata_n),
        .event_valid(event_valid), .event_code(event_code), .event_ext(event_ext),
        .event_break(event_break), .event_repeat(event_repeat), .ascii(ascii),
        .key_held(key_held), .held_code(held_code), .press_count(press_count),
        .err_overflow(err_overflow), .err_seq(err_seq)
    );

    typedef struct {
        logic [7:0] code;
        logic       ext, brk, rep;
        logic [7:0] asc;
        logic [7:0] cnt;
        logic       held;
        logic [8:0] hcode;
    } ev_t;

    int checks = 0;
    int failures = 0;
    logic [7:0] q[$];
    ev_t        log_q[$];
    logic [7:0] amap [256];

    // reference model state: pending prefixes as flags, held key, counters
    bit         m_e0, m_f0, m_held, m_errseq, m_errovf, m_shl, m_shr;
    logic [8:0] m_hcode;
    logic [7:0] m_cnt;
    bit         x_ev, x_ext, x_brk, x_rep;
    logic [7:0] x_code, x_asc;

    bit         pend_vld, prev_ready, prev_pop, ovf_req;
    logic [7:0] pend_byte;
    int         pops, consec;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_byte(input logic [7:0] b);
        bit is_sh, match, upper;
        x_ev = 1'b0;
        if (b == 8'hE0) begin
            if (m_e0 || m_f0) m_errseq = 1'b1;
            m_e0 = 1'b1;
            m_f0 = 1'b0;
        end else if (b == 8'hF0) begin
            if (m_f0) begin
                m_errseq = 1'b1;
                m_e0 = 1'b0;
            end
            m_f0 = 1'b1;
        end else if (!m_e0 && !m_f0 && b == 8'hAA) begin
            x_ev = 1'b0;
        end else begin
            x_ev   = 1'b1;
            x_code = b;
            x_ext  = m_e0;
            x_brk  = m_f0;
            m_e0   = 1'b0;
            m_f0   = 1'b0;
`ifdef SHIFT_CASE_EN
            is_sh = !x_ext && (b == 8'h12 || b == 8'h59);
`else
            is_sh = 1'b0;
`endif
            match = m_held && (m_hcode == {x_ext, b});
            upper = m_shl || m_shr;
            x_asc = x_ext ? 8'h00 : amap[b];
            if (upper && x_asc >= 8'h61 && x_asc <= 8'h7A) x_asc = x_asc - 8'h20;
            x_rep = !x_brk && match && !is_sh;
            if (is_sh) begin
                if (b == 8'h12) m_shl = !x_brk;
                else            m_shr = !x_brk;
            end else if (!x_brk) begin
                if (!match) begin
                    m_cnt   = m_cnt + 8'd1;
                    m_held  = 1'b1;
                    m_hcode = {x_ext, b};
                end
            end else if (match) begin
                m_held = 1'b0;
            end
        end
    endtask

    // One clock: model the edge just passed, compare, then act as the receiver FIFO
    task automatic cycle();
        bit exp_pop;
        ev_t e;
        @(negedge clk);
        if (ps2_overflow) begin
            m_errovf = 1'b1;
            m_e0 = 1'b0;
            m_f0 = 1'b0;
        end
        x_ev = 1'b0;
        if (pend_vld) model_byte(pend_byte);
        exp_pop = prev_ready && !prev_pop;
        chk("nextdata_n", 32'(ps2_nextdata_n), 32'(!exp_pop));
        chk("event_valid", 32'(event_valid), 32'(x_ev));
        if (x_ev) begin
            chk("event_code", 32'(event_code), 32'(x_code));
            chk("event_ext", 32'(event_ext), 32'(x_ext));
            chk("event_break", 32'(event_break), 32'(x_brk));
            chk("event_repeat", 32'(event_repeat), 32'(x_rep));
            chk("ascii", 32'(ascii), 32'(x_asc));
        end
        chk("key_held", 32'(key_held), 32'(m_held));
        chk("held_code", 32'(held_code), 32'(m_hcode));
        chk("press_count", 32'(press_count), 32'(m_cnt));
        chk("err_overflow", 32'(err_overflow), 32'(m_errovf));
        chk("err_seq", 32'(err_seq), 32'(m_errseq));
        if (event_valid) begin
            e.code = event_code; e.ext = event_ext; e.brk = event_break; e.rep = event_repeat;
            e.asc = ascii; e.cnt = press_count; e.held = key_held; e.hcode = held_code;
            log_q.push_back(e);
        end
        pend_vld = 1'b0;
        if (!ps2_nextdata_n) begin
            pops++;
            if (prev_pop) consec++;
            if (q.size() > 0) begin
                pend_byte = q.pop_front();
                pend_vld  = 1'b1;
            end
        end
        prev_pop     = !ps2_nextdata_n;
        ps2_overflow = ovf_req && !pend_vld;
        ovf_req      = 1'b0;
        ps2_ready    = (q.size() > 0);
        ps2_data     = ps2_ready ? q[0] : 8'($urandom_range(0, 255));
        prev_ready   = ps2_ready;
    endtask

    task automatic drain(input int n);
        repeat (n) cycle();
    endtask

    task automatic do_reset();
        clrn = 1'b0;
        ps2_ready = 1'b0;
        ps2_overflow = 1'b0;
        #1;
        chk("rst nextdata_n", 32'(ps2_nextdata_n), 32'd1);
        chk("rst event_valid", 32'(event_valid), 32'd0);
        chk("rst event_code", 32'(event_code), 32'd0);
        chk("rst event_ext", 32'(event_ext), 32'd0);
        chk("rst event_break", 32'(event_break), 32'd0);
        chk("rst event_repeat", 32'(event_repeat), 32'd0);
        chk("rst ascii", 32'(ascii), 32'd0);
        chk("rst key_held", 32'(key_held), 32'd0);
        chk("rst held_code", 32'(held_code), 32'd0);
        chk("rst press_count", 32'(press_count), 32'd0);
        chk("rst err_overflow", 32'(err_overflow), 32'd0);
        chk("rst err_seq", 32'(err_seq), 32'd0);
        m_e0 = 0; m_f0 = 0; m_held = 0; m_errseq = 0; m_errovf = 0; m_shl = 0; m_shr = 0;
        m_hcode = '0; m_cnt = '0;
        q.delete(); log_q.delete();
        pend_vld = 0; prev_ready = 0; prev_pop = 0; ovf_req = 0; pops = 0; consec = 0;
        @(negedge clk);
        clrn = 1'b1;
    endtask

    task automatic push3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        q.push_back(a); q.push_back(b); q.push_back(c);
    endtask

    task automatic gen_token();
        logic [7:0] pool [12] = '{8'h1C, 8'h32, 8'h45, 8'h75, 8'h16, 8'h29,
                                  8'h5A, 8'h66, 8'h12, 8'h59, 8'hAA, 8'h0E};
        logic [7:0] junk [3] = '{8'hE0, 8'hF0, 8'hAA};
        int r = $urandom_range(0, 9);
        logic [7:0] c = $urandom_range(0, 1) ? pool[$urandom_range(0, 3)] : pool[$urandom_range(0, 11)];
        if (r < 5) begin
            if ($urandom_range(0, 3) == 0) q.push_back(8'hE0);
            q.push_back(c);
        end else if (r < 8) begin
            if ($urandom_range(0, 3) == 0) q.push_back(8'hE0);
            q.push_back(8'hF0);
            q.push_back(c);
        end else begin
            q.push_back(junk[$urandom_range(0, 2)]);
        end
    endtask

    initial begin
        logic [7:0] lc [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                                8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                                8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
        logic [7:0] dg [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
        for (int i = 0; i < 256; i++) amap[i] = 8'h00;
        for (int i = 0; i < 26; i++) amap[lc[i]] = 8'h61 + 8'(i);
        for (int i = 0; i < 10; i++) amap[dg[i]] = 8'h30 + 8'(i);
        amap[8'h29] = 8'h20; amap[8'h5A] = 8'h0D; amap[8'h66] = 8'h08;

        #2;
        do_reset();
        push3(8'h1C, 8'hF0, 8'h1C);
        drain(12);
        chk("t1 pops", 32'(pops), 32'd3);
        chk("t1 events", 32'(log_q.size()), 32'd2);
        chk("t1 make code", 32'(log_q[0].code), 32'h1C);
        chk("t1 make ascii", 32'(log_q[0].asc), 32'h61);
        chk("t1 make cnt", 32'(log_q[0].cnt), 32'd1);
        chk("t1 make held", 32'(log_q[0].held), 32'd1);
        chk("t1 brk flag", 32'(log_q[1].brk), 32'd1);
        chk("t1 brk held", 32'(log_q[1].held), 32'd0);

        do_reset();
        q.push_back(8'hE0); q.push_back(8'h75);
        push3(8'hE0, 8'hF0, 8'h75);
        drain(14);
        chk("t2 events", 32'(log_q.size()), 32'd2);
        chk("t2 make ext", 32'(log_q[0].ext), 32'd1);
        chk("t2 make code", 32'(log_q[0].code), 32'h75);
        chk("t2 make ascii", 32'(log_q[0].asc), 32'h00);
        chk("t2 held_code", 32'(log_q[0].hcode), 32'h175);
        chk("t2 brk ext", 32'(log_q[1].ext), 32'd1);
        chk("t2 brk flag", 32'(log_q[1].brk), 32'd1);

        do_reset();
        push3(8'h1C, 8'h1C, 8'h1C);
        q.push_back(8'hF0); q.push_back(8'h1C);
        drain(14);
        chk("t3 events", 32'(log_q.size()), 32'd4);
        chk("t3 rep0", 32'(log_q[0].rep), 32'd0);
        chk("t3 rep1", 32'(log_q[1].rep), 32'd1);
        chk("t3 rep2", 32'(log_q[2].rep), 32'd1);
        chk("t3 press_count", 32'(press_count), 32'd1);

        do_reset();
        push3(8'h16, 8'h1E, 8'h26);
        q.push_back(8'h25);
        drain(12);
        chk("t4 pops", 32'(pops), 32'd4);
        chk("t4 consecutive pops", 32'(consec), 32'd0);
        chk("t4 events", 32'(log_q.size()), 32'd4);
        chk("t4 ascii0", 32'(log_q[0].asc), 32'h31);
        chk("t4 cnt3", 32'(log_q[3].cnt), 32'd4);

        do_reset();
        q.push_back(8'hE0);
        drain(4);
        ovf_req = 1'b1;
        drain(2);
        q.push_back(8'h1C);
        drain(6);
        chk("t5 err_overflow", 32'(err_overflow), 32'd1);
        chk("t5 events", 32'(log_q.size()), 32'd1);
        chk("t5 code", 32'(log_q[0].code), 32'h1C);
        chk("t5 ext", 32'(log_q[0].ext), 32'd0);

        do_reset();
        push3(8'hF0, 8'hE0, 8'h1C);
        drain(10);
        chk("t6 err_seq", 32'(err_seq), 32'd1);
        chk("t6 events", 32'(log_q.size()), 32'd1);
        chk("t6 ext", 32'(log_q[0].ext), 32'd1);
        chk("t6 code", 32'(log_q[0].code), 32'h1C);

        do_reset();
        push3(8'hAA, 8'hF0, 8'hAA);
        drain(10);
        chk("t7 events", 32'(log_q.size()), 32'd1);
        chk("t7 brk code", 32'(log_q[0].code), 32'hAA);

        do_reset();
        q.push_back(8'hE0);
        drain(4);
        do_reset();
        q.push_back(8'h1C);
        drain(6);
        chk("t8 events", 32'(log_q.size()), 32'd1);
        chk("t8 ext", 32'(log_q[0].ext), 32'd0);

        do_reset();
        q.push_back(8'h12); q.push_back(8'h1C);
        drain(8);
        chk("t9 events", 32'(log_q.size()), 32'd2);
`ifdef SHIFT_CASE_EN
        chk("t9 ascii", 32'(log_q[1].asc), 32'h41);
        chk("t9 press_count", 32'(press_count), 32'd1);
`else
        chk("t9 ascii", 32'(log_q[1].asc), 32'h61);
        chk("t9 press_count", 32'(press_count), 32'd2);
`endif

        do_reset();
        for (int n = 0; n < 4000; n++) begin
            if (q.size() < 4 && $urandom_range(0, 2) == 0) gen_token();
            if ($urandom_range(0, 199) == 0) ovf_req = 1'b1;
            cycle();
        end
        drain(16);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/ps2_scancode_decoder.md
Name: ps2_scancode_decoder

Overview:
Downstream consumer of the ps2_keyboard receiver FIFO. It drains bytes over the ready/nextdata_n handshake and assembles set-2 make, break and E0-extended sequences into single key events. It also tracks the currently held key, suppresses typematic repeats from the press counter, and converts codes to ASCII. Outputs drive the seven-segment/LED display logic in the digital-experiment top.

Parameters:
- CNT_W, 8, width of press_count; wraps modulo 2^CNT_W.
- IGNORE_BAT, 1, when 1, byte 0xAA in BASE state is consumed with no event.

Ports:
- clk  in  1  system clock
- clrn  in  1  asynchronous active-low reset
- ps2_data  in  8  head byte of receiver FIFO
- ps2_ready  in  1  FIFO non-empty
- ps2_overflow  in  1  receiver FIFO overflow flag
- ps2_nextdata_n  out  1  active-low pop strobe to receiver
- event_valid  out  1  one-cycle pulse; event fields valid
- event_code  out  8  scancode of event (prefixes stripped)
- event_ext  out  1  event was E0-prefixed
- event_break  out  1  1 = release, 0 = press
- event_repeat  out  1  press of the already-held key (typematic)
- ascii  out  8  ASCII of event_code, 0x00 if unmapped
- key_held  out  1  a key is currently down
- held_code  out  9  {ext, code} of held key
- press_count  out  CNT_W  count of new (non-repeat) presses
- err_overflow  out  1  sticky, set when ps2_overflow is seen
- err_seq  out  1  sticky, set on an illegal prefix order

Behaviour:
- Reset (clrn=0, async): ps2_nextdata_n=1, event_valid=0, all event fields=0, key_held=0, held_code=0, press_count=0, err_*=0, sequence FSM=BASE, handshake FSM=IDLE.
- Handshake FSM (IDLE, POP):
  - In IDLE, ps2_ready=1 at edge E captures ps2_data into byte_q and moves to POP.
  - ps2_nextdata_n=0 for exactly the cycle after E (registered).
  - POP always returns to IDLE, and ps2_ready is not sampled in POP. This gives a maximum of one byte per 2 cycles and prevents a double pop.
- Sequence FSM processes byte_q in the cycle after capture. Any resulting event has event_valid=1 for exactly one cycle starting at edge E+1, so latency is 1 cycle from capture.
  - BASE: E0→EXT; F0→BRK; AA→no event when IGNORE_BAT=1; other→make, ext=0.
  - EXT: F0→EXT_BRK; other→make, ext=1, →BASE.
  - BRK: code→break, ext=0, →BASE.
  - EXT_BRK: code→break, ext=1, →BASE.
  - E0 received in BRK/EXT/EXT_BRK, or F0 received in BRK/EXT_BRK: set err_seq, restart as if the byte arrived in BASE.
- Make event:
  - If key_held and held_code=={ext,code}: event_repeat=1 and press_count unchanged.
  - Otherwise: event_repeat=0, press_count+1 (wraps max→0), held_code←{ext,code}, key_held←1.
- Break event:
  - If it matches held_code: key_held←0, held_code keeps its last value.
  - A non-matching break is still emitted; held state is unchanged.
- ASCII is registered with the event and is 0x00 for ext=1.
  - Letters, lowercase: 1C a, 32 b, 21 c, 23 d, 24 e, 2B f, 34 g, 33 h, 43 i, 3B j, 42 k, 4B l, 3A m, 31 n, 44 o, 4D p, 15 q, 2D r, 1B s, 2C t, 3C u, 2A v, 1D w, 22 x, 35 y, 1A z.
  - Digits: 45 '0', 16 '1', 1E '2', 26 '3', 25 '4', 2E '5', 36 '6', 3D '7', 3E '8', 46 '9'.
  - Others: 29→0x20, 5A→0x0D, 66→0x08; all other codes→0x00.
- ps2_overflow=1 on any edge:
  - err_overflow←1 (sticky until reset).
  - Sequence FSM→BASE, discarding any partial prefix.
  - The handshake continues draining.
- Reset asserted mid-sequence or during POP: immediate return to reset values; a half-received prefix is lost.

Optional Feature:
- SHIFT_CASE_EN defined:
  - Track left shift (12) and right shift (59) down/up; the shift keys still emit events.
  - While either shift is down, letters map to uppercase (0x41–0x5A). Digits are unchanged.
  - Shift presses do not update held_code or press_count.
- SHIFT_CASE_EN undefined: letters are always lowercase, and 12/59 are ordinary keys with ascii 0x00.

Test Plan:
- Bytes 1C, F0, 1C → make (code 1C, ascii 0x61, ext 0, press_count 1, key_held 1), then break (key_held 0); exactly 2 event_valid pulses; ps2_nextdata_n pulsed 3 times.
- Bytes E0 75, E0 F0 75 → make then break, both with ext=1, code 75, ascii 0x00; held_code=0x175 between them.
- Bytes 1C 1C 1C F0 1C → 3 makes; event_repeat = 0,1,1; press_count ends at 1.
- ps2_ready held high with 4 queued bytes → pops on alternate cycles, never on consecutive cycles; event_valid follows each captured byte by 1 cycle.
- Byte E0, then ps2_overflow pulse, then 1C → err_overflow=1; the event is make 1C with ext=0.
- Bytes F0 E0 1C → err_seq=1, make with ext=1, code 1C. With SHIFT_CASE_EN: bytes 12, 1C → ascii 0x41, press_count 1.
